game_logic2: RTL and testbench

// - Move engine of the 2048 game: applies one slide (up/down/left/right) to a 4x4 board of 12-bit tiles.
// - Three registered phases: compact, merge, compact; result on matrix_D, completion flagged by ready.
// - Sits between the input/control FSM (drives enable/direction) and the tile spawner/display.

---
 rtl/game_pkg.sv | 24 ++
 rtl/game_logic2_line_compact.sv | 23 ++
 rtl/game_logic2.sv | 173 +++++++++++++++++
 tb/tb_game_logic2.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the 2048 move engine.
// Boards are indexed [row][col] with row 3 at the top and col 3 leftmost.
package game_pkg;

    typedef logic [11:0] tile_t;
    typedef tile_t board_t [3:0][3:0];
    typedef tile_t line_t [3:0];
    typedef line_t lines_t [3:0];

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        SUM   = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [3:0] DIR_LEFT  = 4'b0001;
    localparam logic [3:0] DIR_RIGHT = 4'b0010;
    localparam logic [3:0] DIR_UP    = 4'b0100;
    localparam logic [3:0] DIR_DOWN  = 4'b1000;

    localparam tile_t MAX_TILE = 12'd2048;

endpackage

// File: rtl/game_logic2_line_compact.sv
// line_compact: slides the non-zero tiles of one line toward index 0.
// Ports: line_i (4 tiles, index 0 at the wall), line_o (compacted line).
module line_compact
    import game_pkg::*;
(
    input  tile_t line_i [3:0],
    output tile_t line_o [3:0]
);

    logic [2:0] k;

    always_comb begin
        line_o = '{default: '0};
        k      = '0;
        for (int i = 0; i < 4; i++) begin
            if (line_i[i] != '0) begin
                line_o[k[1:0]] = line_i[i];
                k = k + 3'd1;
            end
        end
    end

endmodule

// File: rtl/game_logic2.sv
// game_logic2: applies one 2048 slide as compact -> merge -> compact.
// Ports: clk, rst (async low), enable, direction (one-hot), matrix in,
//        matrix_D result, ready (result valid until enable drops).
module game_logic2
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [3:0] direction,
    input  board_t     matrix,
    output board_t     matrix_D,
    output logic       ready
);

    state_t     state_q, state_d;
    board_t     matrix_q, matrix_d;
    logic [3:0] dir_q, dir_d;
    board_t     moved_q, moved_d;
    board_t     summed_q, summed_d;
    board_t     out_q, out_d;
    logic       ready_q, ready_d;

    logic       dir_ok;
    logic [3:0] dir_eff;

    lines_t src1, cmp1;
    lines_t src2, cmp2;
    lines_t sum_l;

    // Index 0 of every line is the tile nearest the destination wall.
    function automatic line_t get_line(
        input board_t     b,
        input logic [3:0] d,
        input int         n
    );
        line_t l;
        for (int k = 0; k < 4; k++) begin
            unique case (1'b1)
                d[0]:    l[k] = b[n][3-k];
                d[1]:    l[k] = b[n][k];
                d[2]:    l[k] = b[3-k][n];
                default: l[k] = b[k][n];
            endcase
        end
        return l;
    endfunction

    function automatic board_t put_lines(
        input lines_t     ls,
        input logic [3:0] d
    );
        board_t b;
        for (int n = 0; n < 4; n++) begin
            for (int k = 0; k < 4; k++) begin
                unique case (1'b1)
                    d[0]:    b[n][3-k] = ls[n][k];
                    d[1]:    b[n][k]   = ls[n][k];
                    d[2]:    b[3-k][n] = ls[n][k];
                    default: b[k][n]   = ls[n][k];
                endcase
            end
        end
        return b;
    endfunction

    // Pair nearest the wall wins; a merged tile is skipped so it
    // cannot merge twice. 2048 never merges, so no overflow.
    function automatic line_t merge_line(input line_t t);
        line_t r;
        logic  skip;
        r    = t;
        skip = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (r[i] != '0 && r[i] == r[i+1]
                         && r[i] != MAX_TILE) begin
                r[i]   = r[i] << 1;
                r[i+1] = '0;
                skip   = 1'b1;
            end
        end
        return r;
    endfunction

    // Invalid direction codes turn the move into a pass-through;
    // dir_eff keeps the line mapping on a legal one-hot code.
    assign dir_ok  = $onehot(dir_q);
    assign dir_eff = dir_ok ? dir_q : DIR_LEFT;

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            src1[n]  = get_line(matrix_q, dir_eff, n);
            sum_l[n] = merge_line(get_line(moved_q, dir_eff, n));
            src2[n]  = get_line(summed_q, dir_eff, n);
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_line
        line_compact u_cmp1 (
            .line_i (src1[g]),
            .line_o (cmp1[g])
        );
        line_compact u_cmp2 (
            .line_i (src2[g]),
            .line_o (cmp2[g])
        );
    end

    always_comb begin
        state_d  = state_q;
        matrix_d = matrix_q;
        dir_d    = dir_q;
        moved_d  = moved_q;
        summed_d = summed_q;
        out_d    = out_q;
        ready_d  = ready_q;
        unique case (state_q)
            IDLE: begin
                ready_d = 1'b0;
                if (enable) begin
                    matrix_d = matrix;
                    dir_d    = direction;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                moved_d = dir_ok ? put_lines(cmp1, dir_eff) : matrix_q;
                state_d = SUM;
            end
            SUM: begin
                summed_d = dir_ok ? put_lines(sum_l, dir_eff) : moved_q;
                state_d  = DONE;
            end
            DONE: begin
                // First DONE cycle publishes; afterwards wait for enable low.
                if (!ready_q) begin
                    out_d   = dir_ok ? put_lines(cmp2, dir_eff) : summed_q;
                    ready_d = 1'b1;
                end else if (!enable) begin
                    ready_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            matrix_q <= '{default: '0};
            dir_q    <= '0;
            moved_q  <= '{default: '0};
            summed_q <= '{default: '0};
            out_q    <= '{default: '0};
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            matrix_q <= matrix_d;
            dir_q    <= dir_d;
            moved_q  <= moved_d;
            summed_q <= summed_d;
            out_q    <= out_d;
            ready_q  <= ready_d;
        end
    end

    assign matrix_D = out_q;
    assign ready    = ready_q;

endmodule

// File: tb/tb_game_logic2.sv
// Scoreboard bench for game_logic2: directed 2048 moves plus random
// boards checked against a queue-based line model.
module tb_game_logic2;
    import game_pkg::*;

    typedef int grid_t [4][4];
    typedef struct {
        board_t b;
        int     due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] direction = '0;
    board_t     matrix;
    board_t     matrix_D;
    logic       ready;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    logic ready_prev = 1'b0;
    exp_t sbq[$];

    game_logic2 dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .direction (direction),
        .matrix    (matrix),
        .matrix_D  (matrix_D),
        .ready     (ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Grids are written as seen: [0] top row, [0] leftmost column.
    function automatic board_t to_board(input grid_t g);
        board_t b;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                b[3-r][3-c] = tile_t'(g[r][c]);
        return b;
    endfunction

    function automatic grid_t to_grid(input board_t b);
        grid_t g;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                g[r][c] = int'(b[3-r][3-c]);
        return g;
    endfunction

    function automatic bit beq(input board_t a, input board_t b);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (a[r][c] !== b[r][c]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic string bstr(input board_t b);
        string s;
        grid_t g;
        s = "";
        g = to_grid(b);
        for (int r = 0; r < 4; r++) begin
            s = {s, "["};
            for (int c = 0; c < 4; c++)
                s = {s, $sformatf("%0d%s", g[r][c], c < 3 ? "," : "")};
            s = {s, "]"};
        end
        return s;
    endfunction

    // Reference: gather each line from the wall outward, fold equal
    // neighbours once (2048 excluded), write back from the wall.
    function automatic board_t model(input board_t b, input logic [3:0] d);
        grid_t g, o;
        int    q[$];
        int    m[$];
        int    r, c, i;
        if (!$onehot(d)) return b;
        g = to_grid(b);
        for (int l = 0; l < 4; l++) begin
            q.delete();
            m.delete();
            for (int p = 0; p < 4; p++) begin
                case (d)
                    DIR_LEFT:  begin r = l;     c = p;     end
                    DIR_RIGHT: begin r = l;     c = 3 - p; end
                    DIR_UP:    begin r = p;     c = l;     end
                    default:   begin r = 3 - p; c = l;     end
                endcase
                if (g[r][c] != 0) q.push_back(g[r][c]);
            end
            i = 0;
            while (i < q.size()) begin
                if (i + 1 < q.size() && q[i] == q[i+1] && q[i] != 2048) begin
                    m.push_back(2 * q[i]);
                    i += 2;
                end else begin
                    m.push_back(q[i]);
                    i += 1;
                end
            end
            for (int p = 0; p < 4; p++) begin
                case (d)
                    DIR_LEFT:  begin r = l;     c = p;     end
                    DIR_RIGHT: begin r = l;     c = 3 - p; end
                    DIR_UP:    begin r = p;     c = l;     end
                    default:   begin r = 3 - p; c = l;     end
                endcase
                o[r][c] = (p < m.size()) ? m[p] : 0;
            end
        end
        return to_board(o);
    endfunction

    task automatic chk(input bit ok, input string name,
                       input string got, input string exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %s expected %s", name, got, exp);
        end
    endtask

    // Monitor: each rising ready pops one expected result.
    always @(negedge clk) begin
        exp_t e;
        if (ready && !ready_prev) begin
            if (sbq.size() == 0) begin
                chk(1'b0, "unexpected_ready", "ready=1", "no move pending");
            end else begin
                e = sbq.pop_front();
                chk(beq(matrix_D, e.b), "result", bstr(matrix_D), bstr(e.b));
                chk(cyc == e.due, "latency",
                    $sformatf("edge %0d", cyc), $sformatf("edge %0d", e.due));
            end
        end
        ready_prev <= ready;
    end

    function automatic board_t rand_board();
        board_t b;
        int     v;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                v = $urandom_range(0, 11);
                if ($urandom_range(0, 2) == 0) v = 0;
                b[r][c] = (v == 0) ? 12'd0 : tile_t'(1 << v);
            end
        return b;
    endfunction

    task automatic do_move(input board_t b, input logic [3:0] d,
                           input board_t exp, input int hold);
        exp_t e;
        @(negedge clk);
        matrix    = b;
        direction = d;
        enable    = 1'b1;
        e.b   = exp;
        e.due = cyc + 4;
        sbq.push_back(e);
        @(negedge clk);
        // Inputs must be ignored once the move is under way.
        matrix    = rand_board();
        direction = ~d;
        for (int i = 0; i < 8 && !ready; i++) @(negedge clk);
        chk(ready, "ready_timeout", $sformatf("%b", ready), "1");
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk(ready && beq(matrix_D, exp), "hold",
                $sformatf("ready=%b %s", ready, bstr(matrix_D)),
                $sformatf("ready=1 %s", bstr(exp)));
        end
        enable = 1'b0;
        @(negedge clk);
        chk(!ready && beq(matrix_D, exp), "release",
            $sformatf("ready=%b %s", ready, bstr(matrix_D)),
            $sformatf("ready=0 %s", bstr(exp)));
    endtask

    grid_t g_left_in  = '{'{2,0,0,0}, '{4,4,128,128}, '{8,0,8,0}, '{16,16,0,2}};
    grid_t g_left_out = '{'{2,0,0,0}, '{8,256,0,0}, '{16,0,0,0}, '{32,2,0,0}};
    grid_t g_right_in = '{'{2,2,2,2}, '{0,0,0,0}, '{0,0,0,0}, '{0,0,0,0}};
    grid_t g_right_out= '{'{0,0,4,4}, '{0,0,0,0}, '{0,0,0,0}, '{0,0,0,0}};
    grid_t g_up_in    = '{'{0,0,0,0}, '{4,0,0,0}, '{4,0,0,0}, '{4,0,0,0}};
    grid_t g_up_out   = '{'{8,0,0,0}, '{4,0,0,0}, '{0,0,0,0}, '{0,0,0,0}};
    grid_t g_dense    = '{'{2,128,32,2}, '{4,8,128,64}, '{8,512,8,2}, '{64,16,1024,32}};
    grid_t g_max      = '{'{2048,2048,0,0}, '{0,0,0,0}, '{0,0,0,0}, '{0,0,0,0}};
    grid_t g_three    = '{'{2,2,2,0}, '{0,0,0,0}, '{0,0,0,0}, '{0,0,0,0}};
    grid_t g_three_o  = '{'{4,2,0,0}, '{0,0,0,0}, '{0,0,0,0}, '{0,0,0,0}};
    grid_t g_zero     = '{'{0,0,0,0}, '{0,0,0,0}, '{0,0,0,0}, '{0,0,0,0}};

    initial begin
        board_t b, zb;
        logic [3:0] d;
        int sel;
        zb = to_board(g_zero);
        matrix = zb;
        #12;
        chk(!ready && beq(matrix_D, zb), "reset_state",
            $sformatf("ready=%b %s", ready, bstr(matrix_D)), "ready=0 zeros");
        @(negedge clk);
        rst = 1'b1;

        do_move(to_board(g_left_in), DIR_LEFT, to_board(g_left_out), 10);

        // Abort a move in SUM with the asynchronous reset.
        @(negedge clk);
        matrix    = to_board(g_right_in);
        direction = DIR_RIGHT;
        enable    = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk(!ready && beq(matrix_D, zb) && dut.state_q == IDLE, "async_reset",
            $sformatf("ready=%b state=%0d %s", ready, dut.state_q, bstr(matrix_D)),
            "ready=0 state=0 zeros");
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        do_move(to_board(g_right_in), DIR_RIGHT, to_board(g_right_out), 0);
        do_move(to_board(g_up_in), DIR_UP, to_board(g_up_out), 0);
        do_move(to_board(g_dense), DIR_LEFT, to_board(g_dense), 1);
        do_move(to_board(g_max), DIR_LEFT, to_board(g_max), 0);
        do_move(to_board(g_three), DIR_LEFT, to_board(g_three_o), 0);
        do_move(to_board(g_left_in), 4'b0000, to_board(g_left_in), 0);
        do_move(to_board(g_left_in), 4'b0011, to_board(g_left_in), 0);
        do_move(zb, DIR_DOWN, zb, 0);

        for (int n = 0; n < 60; n++) begin
            b   = rand_board();
            sel = $urandom_range(0, 9);
            if (sel < 8) d = 4'(1 << (sel % 4));
            else if (sel == 8) d = 4'b0000;
            else d = 4'($urandom_range(0, 15));
            do_move(b, d, model(b, d), $urandom_range(0, 2));
        end

        repeat (3) @(negedge clk);
        chk(sbq.size() == 0, "scoreboard_drain",
            $sformatf("%0d pending", sbq.size()), "0 pending");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
